// File: rtl/mmss_bcd_counter_if.sv
// Front-panel control and BCD time bus between the MM:SS counter and its neighbours.
// The master drives the tick and buttons. The slave returns the registered digits and strobes.
interface mmss_bcd_counter_if;
  logic       tick_1Hz;
  logic       run;
  logic       clr;
  logic       inc_min;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       sec_pulse;
  logic       wrap;

  modport master (
    output tick_1Hz, run, clr, inc_min,
    input  sec_ones, sec_tens, min_ones, min_tens, sec_pulse, wrap
  );

  modport slave (
    input  tick_1Hz, run, clr, inc_min,
    output sec_ones, sec_tens, min_ones, min_tens, sec_pulse, wrap
  );
endinterface

// File: rtl/mmss_bcd_counter.sv
// MM:SS BCD elapsed-time counter advanced by synchronised rising edges of a 1 Hz tick.
// Provides run/clear/minute-set controls. Every output is registered.
module mmss_bcd_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MINUTES = 60
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  mmss_bcd_counter_if.slave    bus
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned MIN_W = 2 * DIG_W;
  localparam logic [MIN_W-1:0] MIN_LAST = {DIG_W'((MAX_MINUTES - 1) / 10),
                                           DIG_W'((MAX_MINUTES - 1) % 10)};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [DIG_W-1:0]       sec_ones_q, sec_ones_d;
  logic [DIG_W-1:0]       sec_tens_q, sec_tens_d;
  logic [MIN_W-1:0]       min_q, min_d;
  logic                   sec_pulse_q, sec_pulse_d;
  logic                   wrap_q, wrap_d;
  logic                   tick_edge_c;

  // BCD minute increment, returning to 00 after the last legal minute
  function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m);
    if (m == MIN_LAST) return '0;
    if (m[3:0] == DIG_W'(9)) return {m[7:4] + DIG_W'(1), DIG_W'(0)};
    return {m[7:4], m[3:0] + DIG_W'(1)};
  endfunction

  assign tick_edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.tick_1Hz};
    prev_d      = sync_q[SYNC_STAGES-1];
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_d       = min_q;
    sec_pulse_d = 1'b0;
    wrap_d      = 1'b0;

    if (bus.clr) begin
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_d      = '0;
    end else begin
      if (tick_edge_c && bus.run) begin
        sec_pulse_d = 1'b1;
        if (sec_ones_q != DIG_W'(9)) begin
          sec_ones_d = sec_ones_q + DIG_W'(1);
        end else begin
          sec_ones_d = '0;
          if (sec_tens_q != DIG_W'(5)) begin
            sec_tens_d = sec_tens_q + DIG_W'(1);
          end else begin
            sec_tens_d = '0;
            wrap_d     = (min_q == MIN_LAST);
            min_d      = min_step(min_q);
          end
        end
      end
      // A coincident minute-set applies on top of the tick result
      if (bus.inc_min) min_d = min_step(min_d);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      sec_ones_q  <= '0;
      sec_tens_q  <= '0;
      min_q       <= '0;
      sec_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_q       <= min_d;
      sec_pulse_q <= sec_pulse_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.sec_ones  = sec_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.min_ones  = min_q[3:0];
  assign bus.min_tens  = min_q[7:4];
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_mmss_bcd_counter.sv
// Bench for mmss_bcd_counter: an elapsed-seconds reference model is checked every cycle.
// Directed scenarios pin the model and the DUT with literal expectations.
module tb_mmss_bcd_counter;

  localparam int S    = 2;
  localparam int MAXM = 60;

  logic clk_50MHz = 1'b0;
  logic rst       = 1'b1;
  always #10 clk_50MHz = ~clk_50MHz;

  mmss_bcd_counter_if bus ();

  mmss_bcd_counter #(.SYNC_STAGES(S), .MAX_MINUTES(MAXM)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus)
  );

  int n_pass    = 0;
  int n_total   = 0;
  int pulse_cnt = 0;

  // Reference: minutes/seconds as plain integers; a rising tick counts S edges after it is first sampled
  bit hist [0:S];
  int m_min = 0;
  int m_sec = 0;
  bit m_pulse = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk_50MHz) begin
    bit rise;
    if (rst) begin
      foreach (hist[i]) hist[i] = 1'b0;
      m_min   = 0;
      m_sec   = 0;
      m_pulse = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      rise = hist[S-1] && !hist[S];
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.tick_1Hz;
      m_pulse = 1'b0;
      m_wrap  = 1'b0;
      if (bus.clr) begin
        m_min = 0;
        m_sec = 0;
      end else begin
        if (rise && bus.run) begin
          m_pulse = 1'b1;
          m_sec   = m_sec + 1;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min = m_min + 1;
            if (m_min == MAXM) begin
              m_min  = 0;
              m_wrap = 1'b1;
            end
          end
        end
        if (bus.inc_min) m_min = (m_min + 1) % MAXM;
      end
    end
    m_valid = 1'b1;
  end

  function automatic logic [31:0] dut_vec();
    return {14'd0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.sec_pulse, bus.wrap};
  endfunction

  function automatic logic [31:0] model_vec();
    return {14'd0, 4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), m_pulse, m_wrap};
  endfunction

  function automatic logic [31:0] lit(input logic [15:0] mmss, input logic pulse, input logic wr);
    return {14'd0, mmss, pulse, wr};
  endfunction

  always @(negedge clk_50MHz) begin
    if (m_valid) begin
      n_total = n_total + 1;
      if (dut_vec() === model_vec()) n_pass = n_pass + 1;
      else $display("FAIL model_cmp t=%0t dut=%h expected=%h", $time, dut_vec(), model_vec());
      if (bus.sec_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s t=%0t dut=%h expected=%h", name, $time, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic tick_rise();
    bus.tick_1Hz = 1'b1;
    cyc(S + 1);
  endtask

  task automatic tick_fall();
    bus.tick_1Hz = 1'b0;
    cyc(S + 1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_rise();
      tick_fall();
    end
  endtask

  task automatic inc_mins(input int n);
    repeat (n) begin
      bus.inc_min = 1'b1;
      cyc(1);
      bus.inc_min = 1'b0;
    end
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    // Reset with tick, run and inc_min all active
    rst = 1'b1;
    bus.tick_1Hz = 1'b1;
    bus.run      = 1'b1;
    bus.clr      = 1'b0;
    bus.inc_min  = 1'b1;
    cyc(1);
    chk("reset", dut_vec(), lit(16'h0000, 1'b0, 1'b0));
    cyc(1);
    rst = 1'b0;
    bus.tick_1Hz = 1'b0;
    bus.inc_min  = 1'b0;
    cyc(S + 2);
    chk("reset_idle", dut_vec(), lit(16'h0000, 1'b0, 1'b0));

    // Latency and single count for a long high level
    pulse_cnt = 0;
    bus.tick_1Hz = 1'b1;
    cyc(S);
    chk("latency_early", dut_vec(), lit(16'h0000, 1'b0, 1'b0));
    cyc(1);
    chk("latency_edge", dut_vec(), lit(16'h0001, 1'b1, 1'b0));
    chk("model_pin_first", model_vec(), lit(16'h0001, 1'b1, 1'b0));
    cyc(1000 - (S + 1));
    chk("hold_one_pulse", 32'(pulse_cnt), 32'd1);
    tick_fall();
    chk("hold_value", dut_vec(), lit(16'h0001, 1'b0, 1'b0));

    // Second-to-minute and minute-units-to-tens carries
    do_clr();
    ticks(59);
    chk("at_0059", dut_vec(), lit(16'h0059, 1'b0, 1'b0));
    tick_rise();
    chk("carry_0100", dut_vec(), lit(16'h0100, 1'b1, 1'b0));
    tick_fall();
    inc_mins(8);
    ticks(59);
    chk("at_0959", dut_vec(), lit(16'h0959, 1'b0, 1'b0));
    tick_rise();
    chk("carry_1000", dut_vec(), lit(16'h1000, 1'b1, 1'b0));
    tick_fall();

    // Full wrap 59:59 -> 00:00
    do_clr();
    inc_mins(59);
    ticks(59);
    chk("at_5959", dut_vec(), lit(16'h5959, 1'b0, 1'b0));
    tick_rise();
    chk("wrap", dut_vec(), lit(16'h0000, 1'b1, 1'b1));
    chk("model_pin_wrap", model_vec(), lit(16'h0000, 1'b1, 1'b1));
    cyc(1);
    chk("wrap_one_cycle", dut_vec(), lit(16'h0000, 1'b0, 1'b0));
    tick_fall();

    // Clear coincident with a counted edge
    do_clr();
    ticks(5);
    bus.tick_1Hz = 1'b1;
    cyc(S);
    bus.clr = 1'b1;
    cyc(1);
    chk("clr_beats_tick", dut_vec(), lit(16'h0000, 1'b0, 1'b0));
    bus.clr = 1'b0;
    tick_fall();

    // run=0 drops ticks; enabling run during a high level does not count
    ticks(2);
    bus.run = 1'b0;
    ticks(3);
    chk("run_off_hold", dut_vec(), lit(16'h0002, 1'b0, 1'b0));
    pulse_cnt = 0;
    bus.tick_1Hz = 1'b1;
    cyc(S + 3);
    bus.run = 1'b1;
    cyc(S + 3);
    chk("run_on_high_value", dut_vec(), lit(16'h0002, 1'b0, 1'b0));
    chk("run_on_high_pulses", 32'(pulse_cnt), 32'd0);
    tick_fall();
    tick_rise();
    chk("run_next_edge", dut_vec(), lit(16'h0003, 1'b1, 1'b0));
    tick_fall();

    // Minute set: modulo wrap without strobes, and coincident with a tick
    do_clr();
    inc_mins(59);
    ticks(30);
    inc_mins(1);
    chk("inc_wrap_5930", dut_vec(), lit(16'h0030, 1'b0, 1'b0));
    inc_mins(59);
    ticks(29);
    chk("at_5959_again", dut_vec(), lit(16'h5959, 1'b0, 1'b0));
    bus.tick_1Hz = 1'b1;
    cyc(S);
    bus.inc_min = 1'b1;
    cyc(1);
    chk("tick_plus_inc", dut_vec(), lit(16'h0100, 1'b1, 1'b1));
    bus.inc_min = 1'b0;
    tick_fall();

    // Randomised traffic against the model
    repeat (4000) begin
      if ($urandom_range(3) == 0) bus.tick_1Hz = ~bus.tick_1Hz;
      bus.run     = ($urandom_range(7) != 0);
      bus.clr     = ($urandom_range(399) == 0);
      bus.inc_min = ($urandom_range(5) == 0);
      rst         = ($urandom_range(599) == 0);
      cyc(1);
    end
    rst         = 1'b0;
    bus.clr     = 1'b0;
    bus.inc_min = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
